// File: rtl/hpm_counter_bank_pkg.sv
// Shared definitions for the machine-mode counter bank: CSR addresses and
// the decoded form of a CSR access.
package hpm_counter_bank_pkg;

    localparam logic [11:0] MCYCLE        = 12'hB00;
    localparam logic [11:0] MINSTRET      = 12'hB02;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CYCLE         = 12'hC00;
    localparam logic [11:0] INSTRET       = 12'hC02;
    localparam logic [11:0] HPMCOUNTER3   = 12'hC03;
    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_CNT,
        ACC_INH,
        ACC_EVT
    } csr_kind_e;

    // idx: counter slot (0 mcycle, 1 minstret, 2+i hpm i) or event slot i
    typedef struct packed {
        csr_kind_e   kind;
        logic        ro;
        logic [4:0]  idx;
    } csr_dec_t;

    function automatic csr_dec_t csr_decode(input logic [11:0] addr, input int num_hpm);
        csr_dec_t d;
        d.kind = ACC_NONE;
        d.ro   = 1'b0;
        d.idx  = '0;
        if (addr == MCYCLE || addr == CYCLE) begin
            d.kind = ACC_CNT;
            d.ro   = (addr == CYCLE);
        end else if (addr == MINSTRET || addr == INSTRET) begin
            d.kind = ACC_CNT;
            d.ro   = (addr == INSTRET);
            d.idx  = 5'd1;
        end else if (addr >= MHPMCOUNTER3 && addr < MHPMCOUNTER3 + 12'(num_hpm)) begin
            d.kind = ACC_CNT;
            d.idx  = 5'(addr - MHPMCOUNTER3) + 5'd2;
        end else if (addr >= HPMCOUNTER3 && addr < HPMCOUNTER3 + 12'(num_hpm)) begin
            d.kind = ACC_CNT;
            d.ro   = 1'b1;
            d.idx  = 5'(addr - HPMCOUNTER3) + 5'd2;
        end else if (addr == MCOUNTINHIBIT) begin
            d.kind = ACC_INH;
        end else if (addr >= MHPMEVENT3 && addr < MHPMEVENT3 + 12'(num_hpm)) begin
            d.kind = ACC_EVT;
            d.idx  = 5'(addr - MHPMEVENT3);
        end
        return d;
    endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// CSR access port between the CSR stage (master) and the counter bank (slave).
interface hpm_counter_bank_if #(
    parameter int XLEN = 64
);
    logic [11:0]     csr_addr;
    logic            csr_re;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_addr, csr_re, csr_we, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_re, csr_we, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/hpm_counter_bank_counter.sv
// One counter slot: a write always beats a same-cycle increment, and the
// sticky overflow flag is cleared only by a CSR write to this counter.
module hpm_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         inhibit,
    input  logic         we,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] count,
    output logic         ovf
);

    // Counter value and sticky wrap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (we) begin
            count <= wdata;
            ovf   <= 1'b0;
        end else if (inc && !inhibit) begin
            count <= count + W'(1);
            if (&count) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// Machine-mode counter bank: mcycle, minstret and NUM_HPM event counters with
// per-counter event selectors, inhibit mask and sticky overflow flags.
module hpm_counter_bank
    import hpm_counter_bank_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  retire_valid,
    input  logic [NUM_EVENTS-1:0] event_vec,
    hpm_counter_bank_if.slave     csr,
    output logic [NUM_HPM+1:0]    ovf
);

    localparam int NCNT = NUM_HPM + 2;
    localparam int IW   = NUM_HPM + 3;
    // bit1 of mcountinhibit has no counter behind it
    localparam logic [IW-1:0] INH_MASK = ~(IW'(2));

    csr_dec_t             dec;
    logic                 wr_ok;
    logic [IW-1:0]        inh_q;
    logic [7:0]           evt_q [NUM_HPM];
    logic [NCNT-1:0]      inc;
    logic [NCNT-1:0]      cnt_inh;
    logic [NCNT-1:0]      cnt_we;
    logic [CNT_WIDTH-1:0] cnt [NCNT];
    logic [XLEN-1:0]      rd;
    logic                 ill;

    assign dec   = csr_decode(csr.csr_addr, NUM_HPM);
    assign wr_ok = csr.csr_we && (dec.kind != ACC_NONE) && !dec.ro;

    // Inhibit mask; a new value only affects increments from the next edge on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inh_q <= '0;
        end else if (wr_ok && dec.kind == ACC_INH) begin
            inh_q <= csr.csr_wdata[IW-1:0] & INH_MASK;
        end
    end

    // Event selectors, 8 bits each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_HPM; i++) begin
                evt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HPM; i++) begin
                if (wr_ok && dec.kind == ACC_EVT && dec.idx == 5'(i)) begin
                    evt_q[i] <= csr.csr_wdata[7:0];
                end
            end
        end
    end

    // Per-slot increment, inhibit and write enables; unmatched selectors never count.
    always_comb begin
        inc        = '0;
        cnt_inh    = '0;
        cnt_we     = '0;
        inc[0]     = 1'b1;
        inc[1]     = retire_valid;
        cnt_inh[0] = inh_q[0];
        cnt_inh[1] = inh_q[2];
        for (int i = 0; i < NUM_HPM; i++) begin
            cnt_inh[i+2] = inh_q[i+3];
            for (int j = 0; j < NUM_EVENTS; j++) begin
                if (evt_q[i] == 8'(j + 1) && event_vec[j]) begin
                    inc[i+2] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NCNT; k++) begin
            cnt_we[k] = wr_ok && dec.kind == ACC_CNT && dec.idx == 5'(k);
        end
    end

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        hpm_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (inc[k]),
            .inhibit (cnt_inh[k]),
            .we      (cnt_we[k]),
            .wdata   (csr.csr_wdata[CNT_WIDTH-1:0]),
            .count   (cnt[k]),
            .ovf     (ovf[k])
        );
    end

    // Read mux and illegal-access flag; reads show the pre-edge state.
    always_comb begin
        rd  = '0;
        ill = 1'b0;
        if (csr.csr_re) begin
            case (dec.kind)
                ACC_CNT: begin
                    for (int k = 0; k < NCNT; k++) begin
                        if (dec.idx == 5'(k)) rd = XLEN'(cnt[k]);
                    end
                end
                ACC_INH: rd = XLEN'(inh_q);
                ACC_EVT: begin
                    for (int i = 0; i < NUM_HPM; i++) begin
                        if (dec.idx == 5'(i)) rd = XLEN'(evt_q[i]);
                    end
                end
                default: ill = 1'b1;
            endcase
        end
        if (csr.csr_we && (dec.kind == ACC_NONE || dec.ro)) begin
            ill = 1'b1;
        end
    end

    assign csr.csr_rdata   = rd;
    assign csr.csr_illegal = ill;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Bench for the counter bank: expected CSR reads are queued as stimulus is
// set up and compared as each read is presented to the DUT.
module tb_hpm_counter_bank;

    localparam int XLEN       = 64;
    localparam int CNT_WIDTH  = 64;
    localparam int NUM_HPM    = 4;
    localparam int NUM_EVENTS = 8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  retire_valid = 1'b0;
    logic [NUM_EVENTS-1:0] event_vec = '0;
    logic [NUM_HPM+1:0]    ovf;

    hpm_counter_bank_if #(.XLEN(XLEN)) csr();

    hpm_counter_bank #(
        .XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH), .NUM_HPM(NUM_HPM), .NUM_EVENTS(NUM_EVENTS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .retire_valid (retire_valid),
        .event_vec    (event_vec),
        .csr          (csr),
        .ovf          (ovf)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
        logic        ill;
        string       name;
    } rd_t;

    rd_t exp_q[$];
    rd_t e;
    int  errors = 0;
    int  checks = 0;

    task automatic expect_rd(input logic [11:0] a, input logic [63:0] d, input logic il, input string n);
        rd_t r;
        r.addr = a; r.data = d; r.ill = il; r.name = n;
        exp_q.push_back(r);
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
        csr.csr_re    = 1'b0;
        csr.csr_addr  = a;
        csr.csr_wdata = d;
        csr.csr_we    = 1'b1;
        @(negedge clk);
        csr.csr_we    = 1'b0;
    endtask

    task automatic test_reset();
        #5;
        expect_rd(12'hB00, 64'd0, 1'b0, "reset_mcycle_during_reset");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        checks++;
        if (ovf !== 6'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b, expected %b", ovf, 6'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        expect_rd(12'hB00, 64'd10, 1'b0, "reset_mcycle_10");
        expect_rd(12'hB02, 64'd0, 1'b0, "reset_minstret_0");
        expect_rd(12'hB03, 64'd0, 1'b0, "reset_hpm3_0");
        expect_rd(12'h320, 64'd0, 1'b0, "reset_inhibit_0");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        csr.csr_addr = 12'hB00; #1;
        checks++;
        if (csr.csr_rdata !== 64'd0 || csr.csr_illegal !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_zero: got rdata=%h illegal=%b, expected rdata=0 illegal=0", csr.csr_rdata, csr.csr_illegal);
        end
    endtask

    task automatic test_events();
        logic [7:0] pat1 [8];
        logic [7:0] pat2 [4];
        pat1 = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02, 8'h02};
        pat2 = '{8'h80, 8'h40, 8'h80, 8'h80};
        csr_write(12'h323, 64'd2);
        for (int i = 0; i < 8; i++) begin
            event_vec = pat1[i];
            @(negedge clk);
        end
        event_vec = '0;
        expect_rd(12'hB03, 64'd5, 1'b0, "evt_hpm3_sel2");
        expect_rd(12'hC03, 64'd5, 1'b0, "evt_hpm3_shadow");
        expect_rd(12'h323, 64'd2, 1'b0, "evt_sel3_readback");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        csr_write(12'h323, 64'(NUM_EVENTS + 1));
        repeat (4) begin
            event_vec = 8'hFF;
            @(negedge clk);
        end
        event_vec = '0;
        expect_rd(12'hB03, 64'd5, 1'b0, "evt_hpm3_sel_out_of_range");
        expect_rd(12'h323, 64'd9, 1'b0, "evt_sel3_readback_9");
        expect_rd(12'hB05, 64'd0, 1'b0, "evt_hpm5_sel0");
        expect_rd(12'h327, 64'd0, 1'b1, "evt_unmapped_sel7");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        csr_write(12'h324, 64'(NUM_EVENTS));
        for (int i = 0; i < 4; i++) begin
            event_vec = pat2[i];
            @(negedge clk);
        end
        event_vec = '0;
        expect_rd(12'hB04, 64'd3, 1'b0, "evt_hpm4_sel_max");
        expect_rd(12'hC04, 64'd3, 1'b0, "evt_hpm4_shadow");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
    endtask

    task automatic test_inhibit();
        csr_write(12'hB00, 64'h200);
        csr_write(12'hB02, 64'h40);
        retire_valid = 1'b1;
        csr_write(12'h320, 64'h5);
        repeat (7) @(negedge clk);
        expect_rd(12'hB00, 64'h202, 1'b0, "inh_mcycle_frozen");
        expect_rd(12'hB02, 64'h41, 1'b0, "inh_minstret_frozen");
        expect_rd(12'h320, 64'h5, 1'b0, "inh_readback");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        csr_write(12'h320, 64'h7);
        expect_rd(12'h320, 64'h5, 1'b0, "inh_bit1_reserved");
        expect_rd(12'hB00, 64'h202, 1'b0, "inh_mcycle_still_frozen");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        csr_write(12'h320, 64'h0);
        expect_rd(12'hB00, 64'h202, 1'b0, "inh_clear_cycle_uses_old");
        expect_rd(12'hB02, 64'h41, 1'b0, "inh_clear_cycle_minstret");
        expect_rd(12'h320, 64'h0, 1'b0, "inh_cleared");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        repeat (2) @(negedge clk);
        expect_rd(12'hB00, 64'h204, 1'b0, "inh_mcycle_resumed");
        expect_rd(12'hB02, 64'h43, 1'b0, "inh_minstret_resumed");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        retire_valid = 1'b0;
    endtask

    task automatic test_wrap();
        csr_write(12'hB00, ONES);
        checks++;
        if (ovf !== 6'b000000) begin
            errors++;
            $display("FAIL wrap_ovf_before: got %b, expected %b", ovf, 6'b000000);
        end
        @(negedge clk);
        expect_rd(12'hB00, 64'd0, 1'b0, "wrap_mcycle_zero");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        checks++;
        if (ovf !== 6'b000001) begin
            errors++;
            $display("FAIL wrap_ovf0_set: got %b, expected %b", ovf, 6'b000001);
        end
        csr_write(12'hB00, 64'h10);
        checks++;
        if (ovf !== 6'b000000) begin
            errors++;
            $display("FAIL wrap_ovf0_cleared: got %b, expected %b", ovf, 6'b000000);
        end
        @(negedge clk);
        expect_rd(12'hB00, 64'h11, 1'b0, "wrap_mcycle_0x11");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        csr_write(12'hB00, ONES);
        csr_write(12'hB00, 64'h5);
        checks++;
        if (ovf !== 6'b000000) begin
            errors++;
            $display("FAIL wrap_write_beats_wrap_ovf: got %b, expected %b", ovf, 6'b000000);
        end
        csr_write(12'hB02, ONES);
        retire_valid = 1'b1;
        @(negedge clk);
        retire_valid = 1'b0;
        @(negedge clk);
        expect_rd(12'hB02, 64'd0, 1'b0, "wrap_minstret_zero");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        checks++;
        if (ovf !== 6'b000010) begin
            errors++;
            $display("FAIL wrap_ovf1_sticky: got %b, expected %b", ovf, 6'b000010);
        end
    endtask

    task automatic test_write_priority();
        retire_valid = 1'b1;
        csr_write(12'hB02, 64'h100);
        retire_valid = 1'b0;
        expect_rd(12'hB02, 64'h100, 1'b0, "prio_minstret_write_wins");
        expect_rd(12'hC02, 64'h100, 1'b0, "prio_instret_shadow");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        checks++;
        if (ovf !== 6'b000000) begin
            errors++;
            $display("FAIL prio_ovf1_cleared_by_write: got %b, expected %b", ovf, 6'b000000);
        end
        csr_write(12'hB00, 64'h300);
        csr.csr_addr  = 12'hC00;
        csr.csr_wdata = 64'h55;
        csr.csr_we    = 1'b1;
        #1;
        checks++;
        if (csr.csr_illegal !== 1'b1) begin
            errors++;
            $display("FAIL prio_write_c00_illegal: got %b, expected 1", csr.csr_illegal);
        end
        @(negedge clk);
        csr.csr_we = 1'b0;
        expect_rd(12'hB00, 64'h301, 1'b0, "prio_mcycle_unchanged_by_c00");
        expect_rd(12'hB07, 64'd0, 1'b1, "prio_unmapped_hpm7");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
    endtask

    task automatic test_async_reset();
        csr_write(12'hB00, ONES);
        @(negedge clk);
        checks++;
        if (ovf !== 6'b000001) begin
            errors++;
            $display("FAIL arst_ovf_before: got %b, expected %b", ovf, 6'b000001);
        end
        #2;
        reset = 1'b1;
        expect_rd(12'hB00, 64'd0, 1'b0, "arst_mcycle");
        expect_rd(12'hB02, 64'd0, 1'b0, "arst_minstret");
        expect_rd(12'hB03, 64'd0, 1'b0, "arst_hpm3");
        expect_rd(12'h323, 64'd0, 1'b0, "arst_sel3");
        expect_rd(12'h7FF, 64'd0, 1'b1, "arst_unmapped_7ff");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
        checks++;
        if (ovf !== 6'b000000) begin
            errors++;
            $display("FAIL arst_ovf: got %b, expected %b", ovf, 6'b000000);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        expect_rd(12'hB00, 64'd3, 1'b0, "arst_resume_mcycle");
        expect_rd(12'h320, 64'd0, 1'b0, "arst_inhibit");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            csr.csr_addr = e.addr; csr.csr_re = 1'b1; #1;
            checks++;
            if (csr.csr_rdata !== e.data || csr.csr_illegal !== e.ill) begin
                errors++;
                $display("FAIL %s: got rdata=%h illegal=%b, expected rdata=%h illegal=%b", e.name, csr.csr_rdata, csr.csr_illegal, e.data, e.ill);
            end
        end
        csr.csr_re = 1'b0;
    endtask

    initial begin
        csr.csr_addr  = '0;
        csr.csr_re    = 1'b0;
        csr.csr_we    = 1'b0;
        csr.csr_wdata = '0;
        test_reset();
        test_events();
        test_inhibit();
        test_wrap();
        test_write_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
